writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DEPTH, default 2: number of entries in the writeback queue (power of two, >=2).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  pipeline result offered.
REQ-005 in_ready  out  1  queue can accept; equals !full, with no dependence on in_valid.
REQ-006 in_rd  in  5  destination register.
REQ-007 in_regwrite  in  1  instruction writes rd.
REQ-008 in_resultsrc  in  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
REQ-009 in_alu, in_memdata, in_pcplus4  in  32 each  candidate results.
REQ-010 in_funct3  in  3  load type; in_addr_lo  in  2  load byte offset.
REQ-011 dbg_valid  in  1  debug write request, single cycle, no handshake.
REQ-012 dbg_rd  in  5; dbg_data  in  32  debug write target and value.
REQ-013 RdW  out  5; ResultW  out  32; RegWriteW  out  1  register-file write port, registered.
REQ-014 retired  out  32  count of pipeline entries written back.
REQ-015 full, empty  out  1 each  queue status.

Function
REQ-016 Push: when in_valid && in_ready at a rising edge, capture all in_* fields into the queue tail.
REQ-017 Output stage, each rising edge, priority order: dbg_valid loads the debug write; else if queue is non-empty, pop head and load the formatted entry; else set RegWriteW to 0.
REQ-018 RegWriteW of a loaded entry = regwrite flag AND (rd != 0); debug write uses (dbg_rd != 0); x0 is never written.
REQ-019 While RegWriteW is 0, RdW and ResultW hold their previous values.
REQ-020 Latency: entry pushed at edge N with an empty queue and no debug request appears on the outputs after edge N+1, and the register file commits it at the following falling edge.
REQ-021 Result select at pop: ALU -> in_alu; PC+4 -> in_pcplus4; load -> formatted in_memdata.
REQ-022 Load format: LB(000)/LBU(100) select byte addr_lo, sign- or zero-extended; LH(001)/LHU(101) select halfword addr_lo[1], sign- or zero-extended; LW(010) and all other codes pass the word unchanged.
REQ-023 Simultaneous push and pop: both occur in the same cycle and the count is unchanged; push while full is refused because in_ready=0.
REQ-024 A debug request stalls popping for that cycle only; queue contents and order are preserved.
REQ-025 Entries retire strictly in push order; read and write pointers wrap modulo DEPTH.
REQ-026 retired increments by 1 per popped entry, including entries with regwrite=0 or rd=0, and excluding debug writes; it wraps 0xFFFFFFFF->0.

Reset
REQ-027 While rst=1 at a rising edge: queue is emptied (pointers and count 0), RegWriteW=0, RdW=0, ResultW=0, retired=0.
REQ-028 After reset, empty=1, full=0, in_ready=1.
REQ-029 Reset mid-operation discards queued entries, and a concurrent push or debug request is ignored.

Structure
REQ-030 Shared package holds the resultsrc encodings (ALU, LOAD, PC4) and the funct3 load codes.
REQ-031 One sub-module, wb_load_align, implements REQ-022 combinationally; the queue and output stage stay in writeback_unit.

Verification
REQ-032 Reset, then push ALU rd=5 value 0x12345678 -> after edge N+1: RegWriteW=1, RdW=5, ResultW=0x12345678; retired=1.
REQ-033 Load LB, memdata 0x0000_80FF, addr_lo=1 -> ResultW=0xFFFFFF80; LHU with addr_lo=2 on 0xBEEF_0001 -> ResultW=0x0000BEEF.
REQ-034 Hold dbg_valid for 3 cycles while pushing 3 entries with DEPTH=2 -> third push waits (in_ready=0), debug writes appear first, then the 3 entries in order.
REQ-035 Push rd=0 value 0xFFFFFFFF with regwrite=1 -> RegWriteW=0 and retired increments.
REQ-036 Assert rst with 2 queued entries -> next cycle empty=1, RegWriteW=0, retired=0, and neither entry is ever written.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared encodings and the queue entry layout for the writeback unit.
package writeback_unit_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } resultsrc_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic [31:0] alu;
    logic [31:0] memdata;
    logic [31:0] pcplus4;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
  } wb_entry_t;

endpackage

// File: rtl/writeback_unit_load_align.sv
// Load data formatting: byte/halfword select with sign or zero extension.
module wb_load_align
  import writeback_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? data[31:16] : data[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback queue feeding a registered register-file write port, with a
// debug write path that pre-empts popping for the cycle it is requested.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_regwrite,
  input  logic [1:0]  in_resultsrc,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_memdata,
  input  logic [31:0] in_pcplus4,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic        dbg_valid,
  input  logic [4:0]  dbg_rd,
  input  logic [31:0] dbg_data,
  output logic [4:0]  RdW,
  output logic [31:0] ResultW,
  output logic        RegWriteW,
  output logic [31:0] retired,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t   mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  wb_entry_t   in_entry, head;
  logic        push, pop, head_we;
  logic [31:0] load_val, head_result;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  // A debug write owns the output port, so the head stays put that cycle.
  assign pop      = !dbg_valid && !empty;

  assign in_entry = '{rd: in_rd, regwrite: in_regwrite, resultsrc: in_resultsrc,
                      alu: in_alu, memdata: in_memdata, pcplus4: in_pcplus4,
                      funct3: in_funct3, addr_lo: in_addr_lo};
  assign head     = mem[rptr];
  assign head_we  = head.regwrite && (head.rd != 5'd0);

  wb_load_align u_align (
    .funct3  (head.funct3),
    .addr_lo (head.addr_lo),
    .data    (head.memdata),
    .result  (load_val)
  );

  always_comb begin
    head_result = head.alu;
    case (head.resultsrc)
      RES_LOAD: head_result = load_val;
      RES_PC4:  head_result = head.pcplus4;
      default:  head_result = head.alu;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wptr] <= in_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // RdW/ResultW only move when a real write is presented; otherwise they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW <= 1'b0;
      RdW       <= '0;
      ResultW   <= '0;
      retired   <= '0;
    end else if (dbg_valid) begin
      RegWriteW <= (dbg_rd != 5'd0);
      if (dbg_rd != 5'd0) begin
        RdW     <= dbg_rd;
        ResultW <= dbg_data;
      end
    end else if (!empty) begin
      RegWriteW <= head_we;
      if (head_we) begin
        RdW     <= head.rd;
        ResultW <= head_result;
      end
      retired <= retired + 32'd1;
    end else begin
      RegWriteW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized and directed bench for writeback_unit against a queue-based model.
module tb_writeback_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic [1:0]  in_resultsrc;
  logic [31:0] in_alu, in_memdata, in_pcplus4;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        dbg_valid;
  logic [4:0]  dbg_rd;
  logic [31:0] dbg_data;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        RegWriteW;
  logic [31:0] retired;
  logic        full, empty;

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .in_resultsrc(in_resultsrc),
    .in_alu(in_alu), .in_memdata(in_memdata), .in_pcplus4(in_pcplus4),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_data(dbg_data),
    .RdW(RdW), .ResultW(ResultW), .RegWriteW(RegWriteW),
    .retired(retired), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned rd;
    bit          regwrite;
    int unsigned src;
    logic [31:0] alu, memdata, pc4;
    int unsigned f3;
    int unsigned alo;
  } ent_t;

  ent_t        m_q[$];
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_res;
  logic [31:0] m_retired;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_result(ent_t e);
    logic [31:0] b, h;
    b = (e.memdata >> (8 * e.alo)) % 256;
    h = (e.memdata >> (16 * (e.alo / 2))) % 65536;
    if (e.src == 2) return e.pc4;
    if (e.src != 1) return e.alu;
    case (e.f3)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4: return b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5: return h;
      default: return e.memdata;
    endcase
  endfunction

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_edge();
    ent_t e;
    bit   ready;
    ready = (m_q.size() < DEPTH);
    if (rst) begin
      m_q.delete();
      m_we = 0; m_rd = 0; m_res = 0; m_retired = 0;
      return;
    end
    if (dbg_valid) begin
      m_we = (dbg_rd != 0);
      if (m_we) begin m_rd = dbg_rd; m_res = dbg_data; end
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = e.regwrite && (e.rd != 0);
      if (m_we) begin m_rd = 5'(e.rd); m_res = model_result(e); end
      m_retired = m_retired + 1;
    end else begin
      m_we = 0;
    end
    if (in_valid && ready) begin
      e.rd = in_rd; e.regwrite = in_regwrite; e.src = in_resultsrc;
      e.alu = in_alu; e.memdata = in_memdata; e.pc4 = in_pcplus4;
      e.f3 = in_funct3; e.alo = in_addr_lo;
      m_q.push_back(e);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("regwrite", 32'(RegWriteW), 32'(m_we));
    check("rd", 32'(RdW), 32'(m_rd));
    check("result", ResultW, m_res);
    check("retired", retired, m_retired);
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("full", 32'(full), 32'(m_q.size() == DEPTH));
    check("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
  endtask

  task automatic idle();
    in_valid = 0; dbg_valid = 0; rst = 0;
  endtask

  task automatic set_push(input logic [4:0] rd, input logic rw, input logic [1:0] src,
                          input logic [31:0] alu, input logic [31:0] md,
                          input logic [31:0] pc4, input logic [2:0] f3, input logic [1:0] alo);
    in_valid = 1; in_rd = rd; in_regwrite = rw; in_resultsrc = src;
    in_alu = alu; in_memdata = md; in_pcplus4 = pc4; in_funct3 = f3; in_addr_lo = alo;
  endtask

  initial begin
    int pushed, cyc;
    bit acc;
    rst = 1; in_valid = 0; dbg_valid = 0; dbg_rd = 0; dbg_data = 0;
    set_push(0, 0, 0, 0, 0, 0, 0, 0); in_valid = 0;
    m_q.delete(); m_we = 0; m_rd = 0; m_res = 0; m_retired = 0;
    step(); step();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd1);

    // ALU result latency
    idle(); set_push(5, 1, 2'b00, 32'h1234_5678, 32'hDEAD_BEEF, 32'h4, 3'b010, 0);
    step();
    idle(); step();
    check("alu_we", 32'(RegWriteW), 32'd1);
    check("alu_rd", 32'(RdW), 32'd5);
    check("alu_res", ResultW, 32'h1234_5678);
    check("alu_ret", retired, 32'd1);

    // LB and LHU formatting
    set_push(7, 1, 2'b01, 0, 32'h0000_80FF, 0, 3'b000, 1); step();
    idle(); step();
    check("lb_res", ResultW, 32'hFFFF_FF80);
    set_push(8, 1, 2'b01, 0, 32'hBEEF_0001, 0, 3'b101, 2); step();
    idle(); step();
    check("lhu_res", ResultW, 32'h0000_BEEF);

    // rd=0 never written but still retired
    set_push(0, 1, 2'b00, 32'hFFFF_FFFF, 0, 0, 0, 0); step();
    idle(); step();
    check("x0_we", 32'(RegWriteW), 32'd0);
    check("x0_ret", retired, 32'd4);

    // Debug writes stall popping; third push waits for space
    pushed = 0; cyc = 0;
    while (pushed < 3 && cyc < 20) begin
      dbg_valid = (cyc < 3); dbg_rd = 5'(10 + cyc); dbg_data = 32'hD000_0000 + cyc;
      set_push(5'(20 + pushed), 1, 2'b10, 0, 0, 32'hA000_0000 + pushed, 0, 0);
      if (cyc == 2) check("dbg_stall_ready", 32'(in_ready), 32'd0);
      acc = (m_q.size() < DEPTH);
      step();
      if (acc) pushed++;
      cyc++;
    end
    check("dbg_pushed", pushed, 3);
    idle();
    repeat (4) step();

    // Reset with two queued entries
    set_push(3, 1, 2'b00, 32'h1111_1111, 0, 0, 0, 0); dbg_valid = 1; dbg_rd = 0; step();
    set_push(4, 1, 2'b00, 32'h2222_2222, 0, 0, 0, 0); dbg_rd = 0; step();
    rst = 1; dbg_valid = 1; dbg_rd = 9; set_push(6, 1, 2'b00, 32'h3333_3333, 0, 0, 0, 0);
    step();
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_we", 32'(RegWriteW), 32'd0);
    check("mid_rst_ret", retired, 32'd0);
    idle();
    repeat (3) begin
      step();
      check("mid_rst_nowrite", 32'(RegWriteW), 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      dbg_valid = ($urandom_range(0, 99) < 15);
      dbg_rd = 5'($urandom); dbg_data = $urandom;
      set_push(5'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom),
               2'($urandom), $urandom, $urandom, $urandom, 3'($urandom), 2'($urandom));
      in_valid = ($urandom_range(0, 99) < 60);
      step();
    end
    idle();
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
